// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (IF / LS) arbiter for the single Ram port
//
// Purpose:
//   Shares the core's single 32-bit Ram port between instruction fetch (IF)
//   and load/store (LS). Owns the Ram address, write-enable and write-data
//   buses; returns read data plus a one-cycle ack to the granted requester.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr              fetch request (held until if_ack) and address
//   if_ack/if_rdata             one-cycle fetch-done pulse and fetched word
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request (held until ls_ack)
//   ls_ack/ls_rdata             one-cycle access-done pulse and loaded word
//   mem_addr/mem_we/mem_wdata   to Ram
//   mem_rdata                   from Ram, valid MEM_LATENCY cycles after ISSUE
//   busy                        arbiter not IDLE
//   owner                       0 = IF, 1 = LS; owner of current/last transaction
//
// Configuration:
//   MEM_PORT_ARB_RR_EN          defined: round-robin on simultaneous requests
//                               undefined: fixed priority, LS over IF
//
// MEM_LATENCY legal range is 1..4; the wait counter is two bits wide.

module mem_port_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Cycles spent in WAIT after ISSUE before mem_rdata is captured.
  localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

  state_t              state_q,     state_d;
  logic [1:0]          cnt_q,       cnt_d;
  logic                owner_q,     owner_d;
  logic                busy_q,      busy_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic                mem_we_q,    mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_ack_q,    if_ack_d;
  logic                ls_ack_q,    ls_ack_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q,  ls_rdata_d;

  logic                grant_ls;

`ifdef MEM_PORT_ARB_RR_EN
  // 1 = LS was granted last, 0 = IF was granted last (reset value).
  logic                last_ls_q,   last_ls_d;

  // On contention the requester that was not granted last wins;
  // a lone requester always wins.
  assign grant_ls = ls_req && (!if_req || !last_ls_q);
`else
  assign grant_ls = ls_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
`ifdef MEM_PORT_ARB_RR_EN
    last_ls_d   = last_ls_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Requests are only looked at here; everything the transaction
        // needs is latched now so later changes on the request side are
        // ignored.
        if (if_req || ls_req) begin
          owner_d     = grant_ls;
          mem_addr_d  = grant_ls ? ls_addr : if_addr;
          mem_we_d    = grant_ls && ls_we;
          mem_wdata_d = grant_ls ? ls_wdata : '0;
          busy_d      = 1'b1;
          state_d     = S_ISSUE;
`ifdef MEM_PORT_ARB_RR_EN
          last_ls_d   = grant_ls;
`endif
        end
      end

      S_ISSUE: begin
        // Write enable is only ever high for this single cycle.
        mem_we_d = 1'b0;
        if (mem_we_q) begin
          // Store: nothing to wait for; ack goes out in RESP.
          ls_ack_d = owner_q;
          if_ack_d = !owner_q;
          state_d  = S_RESP;
        end else begin
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          if (owner_q) begin
            ls_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
          ls_ack_d = owner_q;
          if_ack_d = !owner_q;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      S_RESP: begin
        // Ack is visible this cycle; return to IDLE so a new request is
        // sampled there, never in the same cycle as the ack.
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d   = 1'b0;
        mem_we_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
`ifdef MEM_PORT_ARB_RR_EN
      last_ls_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
`ifdef MEM_PORT_ARB_RR_EN
      last_ls_q   <= last_ls_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign ls_ack    = ls_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: MEM_LATENCY = 1
  logic        a_if_req, a_if_ack, a_ls_req, a_ls_we, a_ls_ack, a_mem_we, a_busy, a_owner;
  logic [31:0] a_if_addr, a_if_rdata, a_ls_addr, a_ls_wdata, a_ls_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  // Instance B: MEM_LATENCY = 3
  logic        b_if_req, b_if_ack, b_ls_req, b_ls_we, b_ls_ack, b_mem_we, b_busy, b_owner;
  logic [31:0] b_if_addr, b_if_rdata, b_ls_addr, b_ls_wdata, b_ls_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  // Preload path into the Ram models
  logic        pl_a_en, pl_b_en;
  logic [8:0]  pl_addr;
  logic [31:0] pl_data;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
    .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_addr(a_ls_addr), .ls_wdata(a_ls_wdata),
    .ls_ack(a_ls_ack), .ls_rdata(a_ls_rdata),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .busy(a_busy), .owner(a_owner)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .ADDR_W(32), .DATA_W(32)) u_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
    .ls_ack(b_ls_ack), .ls_rdata(b_ls_rdata),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .owner(b_owner)
  );

  // Ram model A: one register stage between address and read data.
  logic [31:0] mem_a [512];
  always @(posedge clk) begin
    if (pl_a_en) mem_a[pl_addr] <= pl_data;
    else if (a_mem_we) mem_a[a_mem_addr[8:0]] <= a_mem_wdata;
    a_mem_rdata <= mem_a[a_mem_addr[8:0]];
  end

  // Ram model B: three register stages between address and read data.
  logic [31:0] mem_b [512];
  logic [31:0] b_p0, b_p1;
  always @(posedge clk) begin
    if (pl_b_en) mem_b[pl_addr] <= pl_data;
    else if (b_mem_we) mem_b[b_mem_addr[8:0]] <= b_mem_wdata;
    b_p0        <= mem_b[b_mem_addr[8:0]];
    b_p1        <= b_p0;
    b_mem_rdata <= b_p1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic exp_own [4];

  initial begin
`ifdef MEM_PORT_ARB_RR_EN
    exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    rst_n = 1'b0;
    a_if_req = 0; a_if_addr = 0; a_ls_req = 0; a_ls_we = 0; a_ls_addr = 0; a_ls_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_ls_req = 0; b_ls_we = 0; b_ls_addr = 0; b_ls_wdata = 0;
    pl_a_en = 1'b1; pl_b_en = 1'b0; pl_addr = 9'h0ff; pl_data = 32'h000f0537;
    step(1);
    pl_a_en = 1'b0; pl_b_en = 1'b1; pl_addr = 9'h100; pl_data = 32'h12345678;

    // Reset state
    chk("rst mem_addr", a_mem_addr, 32'h0);
    chk("rst mem_we", a_mem_we, 0);
    chk("rst mem_wdata", a_mem_wdata, 32'h0);
    chk("rst busy", a_busy, 0);
    chk("rst owner", a_owner, 0);
    chk("rst if_ack", a_if_ack, 0);
    chk("rst ls_ack", a_ls_ack, 0);
    chk("rst if_rdata", a_if_rdata, 32'h0);
    chk("rst ls_rdata", a_ls_rdata, 32'h0);
    chk("rst b busy", b_busy, 0);
    step(1);
    pl_b_en = 1'b0;
    rst_n = 1'b1;
    step(1);

    // Single fetch of 0xff, latency 1
    a_if_req = 1; a_if_addr = 32'hff;
    step(1);
    chk("fetch c1 mem_addr", a_mem_addr, 32'hff);
    chk("fetch c1 busy", a_busy, 1);
    chk("fetch c1 mem_we", a_mem_we, 0);
    chk("fetch c1 owner", a_owner, 0);
    step(1);
    chk("fetch c2 if_ack", a_if_ack, 0);
    chk("fetch c2 ls_ack", a_ls_ack, 0);
    step(1);
    chk("fetch c3 if_ack", a_if_ack, 1);
    chk("fetch c3 if_rdata", a_if_rdata, 32'h000f0537);
    chk("fetch c3 ls_ack", a_ls_ack, 0);
    a_if_req = 0;
    step(1);
    chk("fetch c4 if_ack", a_if_ack, 0);
    chk("fetch c4 busy", a_busy, 0);

    // Store 0x58 to 0x79
    a_ls_req = 1; a_ls_we = 1; a_ls_addr = 32'h79; a_ls_wdata = 32'h58;
    step(1);
    chk("store c1 mem_we", a_mem_we, 1);
    chk("store c1 mem_addr", a_mem_addr, 32'h79);
    chk("store c1 mem_wdata", a_mem_wdata, 32'h58);
    chk("store c1 owner", a_owner, 1);
    step(1);
    chk("store c2 mem_we", a_mem_we, 0);
    chk("store c2 ls_ack", a_ls_ack, 1);
    chk("store c2 ls_rdata", a_ls_rdata, 32'h0);
    a_ls_req = 0; a_ls_we = 0;
    step(1);
    chk("store c3 ls_ack", a_ls_ack, 0);

    // Load back from 0x79; wdata changes must not matter
    a_ls_req = 1; a_ls_we = 0; a_ls_addr = 32'h79; a_ls_wdata = 32'hdeadbeef;
    step(1);
    chk("load c1 mem_we", a_mem_we, 0);
    step(2);
    chk("load c3 ls_ack", a_ls_ack, 1);
    chk("load c3 ls_rdata", a_ls_rdata, 32'h58);
    chk("load c3 if_rdata held", a_if_rdata, 32'h000f0537);
    chk("load c3 if_ack", a_if_ack, 0);
    a_ls_req = 0;
    step(1);

    // Reset in the middle of a load of 0x80
    a_ls_req = 1; a_ls_we = 0; a_ls_addr = 32'h80;
    step(2);
    chk("rstmid wait busy", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid mem_we", a_mem_we, 0);
    chk("rstmid busy", a_busy, 0);
    chk("rstmid ls_ack", a_ls_ack, 0);
    a_ls_req = 0;
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("rstmid post busy", a_busy, 0);
    chk("rstmid post owner", a_owner, 0);
    chk("rstmid post ls_ack", a_ls_ack, 0);
    chk("rstmid post mem_addr", a_mem_addr, 32'h0);

    // Contention: LS first, IF after LS drops
    a_if_req = 1; a_if_addr = 32'hff;
    a_ls_req = 1; a_ls_we = 0; a_ls_addr = 32'h79;
    step(1);
    chk("cont c1 owner", a_owner, 1);
    step(2);
    chk("cont c3 ls_ack", a_ls_ack, 1);
    chk("cont c3 if_ack", a_if_ack, 0);
    chk("cont c3 ls_rdata", a_ls_rdata, 32'h58);
    a_ls_req = 0;
    step(1);
    chk("cont c4 busy", a_busy, 0);
    step(1);
    chk("cont c5 owner", a_owner, 0);
    chk("cont c5 busy", a_busy, 1);
    step(2);
    chk("cont c7 if_ack", a_if_ack, 1);
    chk("cont c7 ls_ack", a_ls_ack, 0);
    chk("cont c7 if_rdata", a_if_rdata, 32'h000f0537);
    a_if_req = 0;
    step(1);

    // Both requests held for four transactions
    a_if_req = 1; a_ls_req = 1;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk($sformatf("held%0d owner", k), a_owner, exp_own[k]);
      step(2);
      chk($sformatf("held%0d ls_ack", k), a_ls_ack, exp_own[k]);
      chk($sformatf("held%0d if_ack", k), a_if_ack, !exp_own[k]);
      step(1);
      if (k == 3) begin
        a_if_req = 0; a_ls_req = 0;
      end
    end
    step(1);
    chk("held end busy", a_busy, 0);

    // Latency 3 fetch of 0x100 on instance B
    b_if_req = 1; b_if_addr = 32'h100;
    step(1);
    chk("lat3 c1 busy", b_busy, 1);
    chk("lat3 c1 mem_addr", b_mem_addr, 32'h100);
    b_if_addr = 32'h1ff;
    step(1);
    chk("lat3 c2 busy", b_busy, 1);
    chk("lat3 c2 mem_addr", b_mem_addr, 32'h100);
    b_if_req = 0;
    step(1);
    chk("lat3 c3 busy", b_busy, 1);
    step(1);
    chk("lat3 c4 busy", b_busy, 1);
    chk("lat3 c4 if_ack", b_if_ack, 0);
    step(1);
    chk("lat3 c5 busy", b_busy, 1);
    chk("lat3 c5 if_ack", b_if_ack, 1);
    chk("lat3 c5 if_rdata", b_if_rdata, 32'h12345678);
    chk("lat3 c5 ls_ack", b_ls_ack, 0);
    step(1);
    chk("lat3 c6 busy", b_busy, 0);
    chk("lat3 c6 if_ack", b_if_ack, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit port of the core's Ram between two requesters: instruction fetch (IF) and load/store (LS).
- Owns the memory address, write-enable and write-data buses, and returns read data plus a one-cycle ack to the granted requester.
- Lets the control FSM issue fetch and data accesses without muxing the Ram buses itself.

Parameters:
- MEM_LATENCY, 1: cycles from address presentation (ISSUE cycle) to valid mem_rdata; legal range 1..4.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse: fetch done, if_rdata valid
- if_rdata  out  DATA_W  fetched word
- ls_req  in  1  load/store request; held until ls_ack
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_ack  out  1  one-cycle pulse: access done
- ls_rdata  out  DATA_W  loaded word
- mem_addr  out  ADDR_W  to Ram addr
- mem_we  out  1  to Ram write_enable
- mem_wdata  out  DATA_W  to Ram bus_to_mem_32
- mem_rdata  in  DATA_W  from Ram bus_from_mem_32
- busy  out  1  state != IDLE
- owner  out  1  0 = IF, 1 = LS; owner of the current or last transaction

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - All outputs 0: mem_addr, mem_we, mem_wdata, if_ack, ls_ack, if_rdata, ls_rdata, busy, owner.
  - Priority pointer = IF-last.
  - Reset mid-transaction aborts it; no ack is issued; mem_we drops immediately.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any req, select winner, latch addr/we/wdata and owner, go ISSUE; else stay.
  - ISSUE (1 cycle):
    - Drive mem_addr = latched addr; mem_we = latched we (only ever high in ISSUE); mem_wdata = latched wdata.
    - Store: go RESP. Load/fetch: load counter = MEM_LATENCY-1, go WAIT.
  - WAIT:
    - mem_addr stays driven, mem_we = 0.
    - When counter == 0, capture mem_rdata into the owner's rdata register and go RESP; else decrement.
  - RESP (1 cycle): assert owner's ack; go IDLE.
- Latency, req first seen high in cycle 0 with arbiter IDLE:
  - Load/fetch ack in cycle 2+MEM_LATENCY.
  - Store ack in cycle 2.
  - Minimum spacing between grants is 4 cycles at MEM_LATENCY = 1.
- Fields are latched at grant. Changes to addr/wdata/we after grant are ignored.
- A req dropped before its ack does not cancel the transaction; the ack still pulses.
- Requests are only sampled in IDLE. A req arriving in RESP is served next via IDLE, never the same cycle.
- Arbitration, both reqs high in IDLE: fixed priority, LS wins. IF is served on the following IDLE if still requesting.
- rdata registers hold their value until the next load/fetch completes for that requester. A store does not modify ls_rdata.
- Non-owner ack is never asserted. if_ack and ls_ack are never high together.
- Addresses pass through unmodified; unaligned addresses are legal (Ram handles them).

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests, grant the requester not granted last (pointer updated at each grant). A lone requester is always granted.
- Undefined: fixed priority LS > IF; pointer logic absent.

Test Plan:
- Reset mid-load:
  - Stimulus: ls_req load of 0x80; rst_n low during WAIT.
  - Required: mem_we = 0 and busy = 0 immediately; no ls_ack; after release, IDLE with owner = 0.
- Single fetch, MEM_LATENCY = 1:
  - Stimulus: Ram preloaded 0x000f0537 at 0xff; if_req with if_addr = 0xff in cycle 0.
  - Required: mem_addr = 0xff in cycle 1; if_ack in cycle 3 with if_rdata = 0x000f0537; ls_ack stays 0.
- Store then load:
  - Stimulus: ls_we = 1, addr 0x79, wdata 0x58; then ls_we = 0, addr 0x79.
  - Required: mem_we high exactly one cycle; store ack 2 cycles after req; load ls_rdata = 0x58.
- Contention, macro off:
  - Stimulus: if_req and ls_req both high, held.
  - Required: LS granted first, IF second; acks 4 cycles apart; owner 1 then 0.
- Contention, MEM_PORT_ARB_RR_EN defined:
  - Stimulus: both reqs held high for 4 transactions.
  - Required: grant order LS, IF, LS, IF (pointer starts IF-last).
- MEM_LATENCY = 3:
  - Stimulus: fetch of 0x100.
  - Required: ack in cycle 5; addr changes after grant have no effect; busy high cycles 1..5.
